pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0100: PC value loaded on reset.
REQ-002 SHALL have parameter MEM_LO, default 32'h0000_0100: lowest legal instruction address.
REQ-003 SHALL have parameter MEM_HI, default 32'h0000_03FC: highest legal instruction address.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port Instr, input, 32 bits: instruction word returned by instruction memory for the current PC.
REQ-007 SHALL have port Zero, input, 1 bit: ALU equality flag for the current instruction (1 = operands equal).
REQ-008 SHALL have port Stall, input, 1 bit: hold PC and counter this cycle.
REQ-009 SHALL have port PC, output, 32 bits: current fetch address, driven to instruction memory Addr.
REQ-010 SHALL have port PCPlus4, output, 32 bits: PC + 4, combinational.
REQ-011 SHALL have port Halted, output, 1 bit: high in HALT state.
REQ-012 SHALL have port Fault, output, 1 bit: high in FAULT state.
REQ-013 SHALL have port RetireCnt, output, 16 bits: count of instructions retired.

Function
REQ-014 SHALL implement three states: RUN, HALT, FAULT; reset enters RUN.
REQ-015 SHALL, in RUN with Stall=0, update PC on every rising edge to NextPC; latency is one cycle from Instr/Zero to the new PC.
REQ-016 SHALL compute NextPC by priority: jump (Instr[31:26]=6'h02) -> {PCPlus4[31:28], Instr[25:0], 2'b00}; beq (6'h04) with Zero=1, or bne (6'h05) with Zero=0 -> PCPlus4 + (sign-extended Instr[15:0] << 2); otherwise -> PCPlus4.
REQ-017 SHALL perform all PC arithmetic modulo 2^32; carry-out is discarded.
REQ-018 SHALL detect syscall as Instr[31:26]=6'h00 and Instr[5:0]=6'h0C; in RUN with Stall=0, it SHALL hold PC, move to HALT, and count the syscall as retired.
REQ-019 SHALL, in RUN with Stall=0, move to FAULT instead of updating PC when NextPC < MEM_LO, NextPC > MEM_HI, or NextPC[1:0] != 0; PC keeps the address of the offending instruction.
REQ-020 SHALL give syscall detection priority over the range check.
REQ-021 SHALL, when Stall=1 in any state, hold PC, state and RetireCnt unchanged.
REQ-022 SHALL hold HALT and FAULT until reset; PC and RetireCnt are frozen in both states.
REQ-023 SHALL increment RetireCnt by 1 on each RUN cycle with Stall=0 that updates PC or enters HALT; it SHALL NOT increment on entry to FAULT.
REQ-024 SHALL saturate RetireCnt at 16'hFFFF with no wrap.
REQ-025 SHALL drive Halted and Fault as registered state decodes; they are never high together.
REQ-026 SHALL ignore Instr and Zero outside RUN.

Reset
REQ-027 SHALL, while Reset=1 and independent of Clk, force PC=RESET_PC, state=RUN, RetireCnt=0, Halted=0 and Fault=0.
REQ-028 SHALL, when reset is asserted mid-operation (including in HALT or FAULT), abandon the current state immediately and resume fetch from RESET_PC on the first rising edge after Reset falls.

Verification
REQ-029 SHALL be verified for reset/sequential fetch: release Reset; Instr = add (32'h0000_2020), 3 cycles -> PC 0x100, 0x104, 0x108, 0x10C; RetireCnt=3.
REQ-030 SHALL be verified for branch: PC=0x118, Instr=32'h10A0_0001, Zero=1 -> next PC=0x120; with Zero=0 -> next PC=0x11C.
REQ-031 SHALL be verified for jump: PC=0x11C, Instr=32'h0800_0045 -> next PC=0x114.
REQ-032 SHALL be verified for halt: PC=0x120, Instr=32'h0000_000C -> Halted=1 next cycle; PC stays 0x120; RetireCnt +1, then frozen for 5 further cycles.
REQ-033 SHALL be verified for fault: PC=0x3FC, Instr=add -> Fault=1, PC stays 0x3FC, RetireCnt unchanged; separately, beq with offset 16'h8000 and Zero=1 -> Fault=1.
REQ-034 SHALL be verified for stall and async reset: Stall=1 for 2 cycles -> PC and RetireCnt hold; asserting Reset between clock edges in FAULT -> PC=0x100 and Fault=0 before the next edge.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch PC unit: next-PC selection (sequential/branch/jump),
// syscall halt, address-range fault and a saturating retired-instruction count.
//
// state | meaning
// RUN   | fetching; PC advances every unstalled cycle
// HALT  | syscall retired; PC and count frozen until reset
// FAULT | next PC out of range or misaligned; PC holds offending instruction
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0100,
   parameter logic [31:0] MEM_LO   = 32'h0000_0100,
   parameter logic [31:0] MEM_HI   = 32'h0000_03FC
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Instr,
   input  logic        Zero,
   input  logic        Stall,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        Halted,
   output logic        Fault,
   output logic [15:0] RetireCnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] retire_cnt_q, retire_cnt_d;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        is_jump;
   logic        is_syscall;
   logic        br_taken;
   logic [31:0] pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] next_pc;
   logic        next_pc_bad;
   logic [15:0] retire_cnt_inc;

   always_comb begin
      opcode     = Instr[31:26];
      funct      = Instr[5:0];
      is_jump    = (opcode == OP_J);
      is_syscall = (opcode == OP_SPECIAL) && (funct == FN_SYSCALL);
      br_taken   = ((opcode == OP_BEQ) && Zero) || ((opcode == OP_BNE) && !Zero);

      // All arithmetic is 32-bit so carries out of bit 31 simply drop.
      pc_plus4   = pc_q + 32'd4;
      br_offset  = {{14{Instr[15]}}, Instr[15:0], 2'b00};
      br_target  = pc_plus4 + br_offset;
      jmp_target = {pc_plus4[31:28], Instr[25:0], 2'b00};

      if (is_jump) begin
         next_pc = jmp_target;
      end else if (br_taken) begin
         next_pc = br_target;
      end else begin
         next_pc = pc_plus4;
      end

      next_pc_bad = (next_pc < MEM_LO) || (next_pc > MEM_HI) || (next_pc[1:0] != 2'b00);

      retire_cnt_inc = (retire_cnt_q == 16'hFFFF) ? retire_cnt_q : (retire_cnt_q + 16'd1);
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      retire_cnt_d = retire_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (!Stall) begin
               // Syscall wins over the range check: halting never looks at next_pc.
               if (is_syscall) begin
                  state_d      = ST_HALT;
                  retire_cnt_d = retire_cnt_inc;
               end else if (next_pc_bad) begin
                  state_d = ST_FAULT;
               end else begin
                  pc_d         = next_pc;
                  retire_cnt_d = retire_cnt_inc;
               end
            end
         end
         ST_HALT:  state_d = ST_HALT;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_FAULT;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         retire_cnt_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign PC        = pc_q;
   assign PCPlus4   = pc_plus4;
   assign Halted    = (state_q == ST_HALT);
   assign Fault     = (state_q == ST_FAULT);
   assign RetireCnt = retire_cnt_q;

endmodule
